mult_18_ccff_loader: RTL

MULT_18_CCFF_LOADER -- requirements
Module: mult_18_ccff_loader

---
 rtl/mult_18_ccff_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mult_18_ccff_loader.sv
// Serialises configuration words onto the mult_18 grid scan chain (ccff_head),
// LSB first, with framing checks on the total bit count and cfg_last.
module mult_18_ccff_loader #(
    parameter int unsigned TOTAL_BITS = 40,
    parameter int unsigned WORD_W     = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              config_enable,
    output logic              done,
    output logic              error,
    output logic [15:0]       bit_count
);

    localparam int unsigned RW       = $clog2(WORD_W + 1);
    localparam logic [16:0] TOTAL_W  = 17'(TOTAL_BITS);
    localparam logic [16:0] WORD_LIM = 17'(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] buffer;
    logic [RW-1:0]     remaining;
    logic [15:0]       accepted;
    logic              last_word;

    logic              accept;
    logic              pass_end;
    logic              restart;
    logic [16:0]       left;
    logic [RW-1:0]     take;
    logic [15:0]       count_inc;
    logic              at_total;

    // remaining counts the bit currently on ccff_head, so "one left" means the
    // next edge may load a fresh word without leaving a bubble.
    always_comb begin
        left      = TOTAL_W - {1'b0, accepted};
        take      = RW'((left < WORD_LIM) ? left : WORD_LIM);
        at_total  = ({1'b0, bit_count} >= TOTAL_W);
        count_inc = at_total ? bit_count : bit_count + 16'd1;
        cfg_ready = (state == LOAD) && (remaining <= RW'(1))
                    && ({1'b0, accepted} < TOTAL_W) && !last_word;
        accept    = cfg_valid && cfg_ready;
        pass_end  = (state == LOAD) && !accept && (remaining == RW'(1))
                    && (last_word || at_total);
        restart   = (state != LOAD) && start;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (pass_end) state_next = DONE;
            DONE:    if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            buffer        <= '0;
            remaining     <= '0;
            accepted      <= '0;
            last_word     <= 1'b0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bit_count     <= '0;
        end else if (restart) begin
            buffer        <= '0;
            remaining     <= '0;
            accepted      <= '0;
            last_word     <= 1'b0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bit_count     <= '0;
        end else if (state == LOAD) begin
            if (accept) begin
                buffer        <= cfg_data >> 1;
                remaining     <= take;
                accepted      <= accepted + 16'(take);
                last_word     <= cfg_last;
                ccff_head     <= cfg_data[0];
                config_enable <= 1'b1;
                bit_count     <= count_inc;
            end else if (remaining > RW'(1)) begin
                buffer        <= buffer >> 1;
                remaining     <= remaining - RW'(1);
                ccff_head     <= buffer[0];
                config_enable <= 1'b1;
                bit_count     <= count_inc;
            end else begin
                remaining     <= '0;
                ccff_head     <= 1'b0;
                config_enable <= 1'b0;
                if (pass_end) begin
                    done  <= 1'b1;
                    error <= !(last_word && at_total);
                end
            end
        end else begin
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
        end
    end

endmodule
